// File: rtl/vga_sync_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_pkg
//  Shared video timing package. Holds the default 640x480 @ 72.8 Hz timing
//  numbers (31.5 MHz pixel clock), the raster coordinate type and small
//  helpers for deriving line/frame totals. The sync generator imports it, and
//  so can any other block that needs the same raster geometry.
// ---------------------------------------------------------------------------
package vga_sync_gen_pkg;

  // Raster counters are 11 bits wide, so a line or frame may hold at most
  // 2048 positions.
  localparam int COUNT_W   = 11;
  localparam int MAX_TOTAL = 1 << COUNT_W;

  typedef logic [COUNT_W-1:0] coord_t;
  // One bit wider than a coordinate. Window edges such as "end of sync" may
  // equal 2048, so comparisons are made at this width.
  typedef logic [COUNT_W:0]   coord_wide_t;

  // Default timing: 640x480, 31.5 MHz pixel clock, 832x520 total.
  localparam int DEF_FDIVIDER = 83;
  localparam int DEF_QDIVIDER = 5;
  localparam int DEF_ACTIVE_H = 640;
  localparam int DEF_ACTIVE_V = 480;
  localparam int DEF_HFP      = 24;
  localparam int DEF_HPULSE   = 40;
  localparam int DEF_HBP      = 128;
  localparam int DEF_VFP      = 9;
  localparam int DEF_VPULSE   = 2;
  localparam int DEF_VBP      = 29;

  // Total positions in one line or frame: active + front porch + sync +
  // back porch, in that order.
  function automatic int span_total(input int active, input int fp,
                                    input int pulse, input int bp);
    return active + fp + pulse + bp;
  endfunction

  // First position of the sync pulse (sync follows active and front porch).
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

endpackage

// File: rtl/vga_sync_gen_pll.sv
// ---------------------------------------------------------------------------
// vga_pixel_pll
//  Derives the pixel clock from the 12 MHz board clock.
//  fpx = 12 MHz * (FDivider+1) / 2^QDivider, with DIVR fixed at 0.
//  With USE_PLL=0 the reference clock is passed straight through and lock
//  is held high, which is how the raster logic is simulated.
// Ports
//  clk     in   12 MHz reference clock
//  reset   in   asynchronous active-low reset, drives the PLL's RESETB
//  px_clk  out  pixel clock
//  lock    out  1 once the pixel clock is stable
// ---------------------------------------------------------------------------
module vga_pixel_pll #(
  parameter int FDivider = 83,
  parameter int QDivider = 5,
  parameter int USE_PLL  = 1
) (
  input  logic clk,
  input  logic reset,
  output logic px_clk,
  output logic lock
);

`ifndef SYNTHESIS
  // Divider fields are 7 bits (DIVF) and 3 bits (DIVQ, legal 1..6).
  generate
    if (FDivider < 0 || FDivider > 127) begin : g_bad_fdivider
      $fatal(1, "vga_pixel_pll: FDivider out of range 0..127");
    end
    if (QDivider < 1 || QDivider > 6) begin : g_bad_qdivider
      $fatal(1, "vga_pixel_pll: QDivider out of range 1..6");
    end
  endgenerate
`endif

  generate
    if (USE_PLL != 0) begin : g_pll
`ifdef SYNTHESIS
      SB_PLL40_CORE #(
        .FEEDBACK_PATH("SIMPLE"),
        .DIVR         (4'b0000),
        .DIVF         (7'(FDivider)),
        .DIVQ         (3'(QDivider)),
        .FILTER_RANGE (3'b001)
      ) u_sb_pll (
        .REFERENCECLK (clk),
        .PLLOUTCORE   (px_clk),
        .LOCK         (lock),
        .RESETB       (reset),
        .BYPASS       (1'b0)
      );
`else
      // Simulation stand-in for the hard PLL: same clock, lock follows the
      // PLL reset so the counters still see a lock-gated start.
      assign px_clk = clk;
      assign lock   = reset;
`endif
    end else begin : g_bypass
      assign px_clk = clk;
      assign lock   = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//  VGA timing generator. A PLL turns the 12 MHz board clock into the pixel
//  clock; free-running horizontal and vertical counters on that clock give
//  the raster position, and hsync / vsync / activevideo are decoded from the
//  counter registers with no extra latency.
//  Line and frame order: active, front porch, sync, back porch. (0,0) is the
//  first visible pixel.
// Ports
//  clk          in   12 MHz reference clock
//  reset        in   asynchronous active-low reset
//  hsync        out  horizontal sync, active low
//  vsync        out  vertical sync, active low
//  x_px         out  horizontal position 0..HTOTAL-1
//  y_px         out  vertical position 0..VTOTAL-1
//  activevideo  out  1 inside the visible area
//  px_clk       out  pixel clock; all outputs change on its rising edge
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int FDivider     = DEF_FDIVIDER,
  parameter int QDivider     = DEF_QDIVIDER,
  parameter int activeHvideo = DEF_ACTIVE_H,
  parameter int activeVvideo = DEF_ACTIVE_V,
  parameter int hfp          = DEF_HFP,
  parameter int hpulse       = DEF_HPULSE,
  parameter int hbp          = DEF_HBP,
  parameter int vfp          = DEF_VFP,
  parameter int vpulse       = DEF_VPULSE,
  parameter int vbp          = DEF_VBP,
  parameter int USE_PLL      = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x_px,
  output logic [10:0] y_px,
  output logic        activevideo,
  output logic        px_clk
);

  localparam int HTOTAL   = span_total(activeHvideo, hfp, hpulse, hbp);
  localparam int VTOTAL   = span_total(activeVvideo, vfp, vpulse, vbp);
  localparam int HS_START = sync_start(activeHvideo, hfp);
  localparam int VS_START = sync_start(activeVvideo, vfp);

  localparam coord_t      H_LAST     = coord_t'(HTOTAL - 1);
  localparam coord_t      V_LAST     = coord_t'(VTOTAL - 1);
  localparam coord_wide_t HS_FIRST_W = coord_wide_t'(HS_START);
  localparam coord_wide_t HS_END_W   = coord_wide_t'(HS_START + hpulse);
  localparam coord_wide_t VS_FIRST_W = coord_wide_t'(VS_START);
  localparam coord_wide_t VS_END_W   = coord_wide_t'(VS_START + vpulse);
  localparam coord_wide_t ACT_H_W    = coord_wide_t'(activeHvideo);
  localparam coord_wide_t ACT_V_W    = coord_wide_t'(activeVvideo);

`ifndef SYNTHESIS
  // Both totals must fit the 11-bit counters.
  generate
    if (HTOTAL > MAX_TOTAL || HTOTAL < 2) begin : g_bad_htotal
      $fatal(1, "vga_sync_gen: HTOTAL must be in 2..2048");
    end
    if (VTOTAL > MAX_TOTAL || VTOTAL < 2) begin : g_bad_vtotal
      $fatal(1, "vga_sync_gen: VTOTAL must be in 2..2048");
    end
  endgenerate
`endif

  logic   px_clk_w;
  logic   lock;
  coord_t x_reg;
  coord_t y_reg;

  vga_pixel_pll #(
    .FDivider (FDivider),
    .QDivider (QDivider),
    .USE_PLL  (USE_PLL)
  ) u_pll (
    .clk    (clk),
    .reset  (reset),
    .px_clk (px_clk_w),
    .lock   (lock)
  );

  assign px_clk = px_clk_w;

  // Raster counters. An asserted reset aborts the frame on the spot; while
  // the PLL is unlocked the counters are simply held at the origin so the
  // first frame after lock starts cleanly at (0,0).
  always_ff @(posedge px_clk_w or negedge reset) begin
    if (!reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (!lock) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (x_reg == H_LAST) begin
      x_reg <= '0;
      y_reg <= (y_reg == V_LAST) ? '0 : y_reg + 1'b1;
    end else begin
      x_reg <= x_reg + 1'b1;
    end
  end

  // Decodes are taken straight from the counter registers so they line up
  // with x_px / y_px on the same cycle. vsync only ever changes when y_reg
  // does, i.e. at the start of a line.
  coord_wide_t x_wide;
  coord_wide_t y_wide;
  assign x_wide = {1'b0, x_reg};
  assign y_wide = {1'b0, y_reg};

  assign x_px  = x_reg;
  assign y_px  = y_reg;
  assign hsync = !((x_wide >= HS_FIRST_W) && (x_wide < HS_END_W));
  assign vsync = !((y_wide >= VS_FIRST_W) && (y_wide < VS_END_W));

  // The counters rest at (0,0) during reset, which would otherwise decode
  // as visible; blank explicitly while in reset or unlocked.
  assign activevideo = reset && lock && (x_wide < ACT_H_W) && (y_wide < ACT_V_W);

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//  Two generators run side by side in PLL-bypass mode: one with the default
//  832x520 timing (a few lines, for the horizontal windows) and one with a
//  scaled 64x40 timing so complete frames, the vsync window and the frame
//  wrap fit in a short run. Expected outputs come from the cycle count since
//  reset release: x = t mod HTOTAL, y = (t div HTOTAL) mod VTOTAL, and the
//  sync/active levels follow from the window rules.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  // Scaled timing: HTOTAL = 40+4+6+14 = 64, VTOTAL = 30+3+2+5 = 40.
  localparam int S_AH = 40, S_HFP = 4, S_HP = 6, S_HBP = 14;
  localparam int S_AV = 30, S_VFP = 3, S_VP = 2, S_VBP = 5;
  // Default timing.
  localparam int D_AH = 640, D_HFP = 24, D_HP = 40, D_HBP = 128;
  localparam int D_AV = 480, D_VFP = 9,  D_VP = 2,  D_VBP = 29;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic        s_hsync, s_vsync, s_active, s_pxclk;
  logic [10:0] s_x, s_y;
  logic        d_hsync, d_vsync, d_active, d_pxclk;
  logic [10:0] d_x, d_y;

  int tests = 0;
  int fails = 0;
  int t;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .activeHvideo (S_AH), .activeVvideo (S_AV),
    .hfp (S_HFP), .hpulse (S_HP), .hbp (S_HBP),
    .vfp (S_VFP), .vpulse (S_VP), .vbp (S_VBP),
    .USE_PLL (0)
  ) dut_s (
    .clk (clk), .reset (reset),
    .hsync (s_hsync), .vsync (s_vsync),
    .x_px (s_x), .y_px (s_y),
    .activevideo (s_active), .px_clk (s_pxclk)
  );

  vga_sync_gen #(
    .USE_PLL (0)
  ) dut_d (
    .clk (clk), .reset (reset),
    .hsync (d_hsync), .vsync (d_vsync),
    .x_px (d_x), .y_px (d_y),
    .activevideo (d_active), .px_clk (d_pxclk)
  );

  // Pixel clocks elapsed since reset was last released.
  always @(posedge clk or negedge reset) begin
    if (!reset) t <= 0;
    else        t <= t + 1;
  end

  // Expected {x, y, hsync, vsync, active} for a timing set after n clocks.
  function automatic logic [24:0] model(input int n, input bit in_reset,
                                        input int ah, input int hfp, input int hp, input int hbp,
                                        input int av, input int vfp, input int vp, input int vbp);
    int ht, vt, x, y;
    logic hs, vs, act;
    if (in_reset) return {11'd0, 11'd0, 1'b1, 1'b1, 1'b0};
    ht  = ah + hfp + hp + hbp;
    vt  = av + vfp + vp + vbp;
    x   = n % ht;
    y   = (n / ht) % vt;
    hs  = !(x >= ah + hfp && x < ah + hfp + hp);
    vs  = !(y >= av + vfp && y < av + vfp + vp);
    act = (x < ah) && (y < av);
    return {11'(x), 11'(y), hs, vs, act};
  endfunction

  task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b, expected x=%0d y=%0d hs=%b vs=%b av=%b",
               name, t, got[24:14], got[13:3], got[2], got[1], got[0],
               exp[24:14], exp[13:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %b, expected %b", name, t, got, exp);
    end
  endtask

  task automatic check_xy(input string name, input logic [10:0] gx, input logic [10:0] gy,
                          input int ex, input int ey);
    tests++;
    if (gx !== 11'(ex) || gy !== 11'(ey)) begin
      fails++;
      $display("FAIL %s t=%0d: got (%0d,%0d), expected (%0d,%0d)", name, t, gx, gy, ex, ey);
    end
  endtask

  // Single compare process: runs 1 time unit after every falling clock edge
  // and 1 time unit after reset is asserted (to see the asynchronous clear).
  always begin
    @(negedge clk or negedge reset);
    #1;
    if (clk == 1'b1 && !reset) begin
      check("s_async_reset", {s_x, s_y, s_hsync, s_vsync, s_active},
            {11'd0, 11'd0, 1'b1, 1'b1, 1'b0});
      check("d_async_reset", {d_x, d_y, d_hsync, d_vsync, d_active},
            {11'd0, 11'd0, 1'b1, 1'b1, 1'b0});
    end else begin
      check("s_model", {s_x, s_y, s_hsync, s_vsync, s_active},
            model(t, !reset, S_AH, S_HFP, S_HP, S_HBP, S_AV, S_VFP, S_VP, S_VBP));
      check("d_model", {d_x, d_y, d_hsync, d_vsync, d_active},
            model(t, !reset, D_AH, D_HFP, D_HP, D_HBP, D_AV, D_VFP, D_VP, D_VBP));
      if (reset) begin
        case (t)
          // First edge after release: 0 -> 1.
          1:    check_xy("d_first_edge", d_x, d_y, 1, 0);
          // Default horizontal windows.
          639:  check_bit("d_active_x639", d_active, 1'b1);
          640:  check_bit("d_active_x640", d_active, 1'b0);
          663:  check_bit("d_hsync_x663", d_hsync, 1'b1);
          664:  check_bit("d_hsync_x664", d_hsync, 1'b0);
          703:  check_bit("d_hsync_x703", d_hsync, 1'b0);
          704:  check_bit("d_hsync_x704", d_hsync, 1'b1);
          831:  check_xy("d_line_end", d_x, d_y, 831, 0);
          832:  check_xy("d_line_wrap", d_x, d_y, 0, 1);
          // Scaled vertical windows and frame wrap.
          40:   check_bit("s_active_x40", s_active, 1'b0);
          1895: check_bit("s_active_39_29", s_active, 1'b1);
          1920: check_bit("s_active_0_30", s_active, 1'b0);
          2111: check_bit("s_vsync_63_32", s_vsync, 1'b1);
          2112: begin
            check_xy("s_vsync_fall_pos", s_x, s_y, 0, 33);
            check_bit("s_vsync_fall", s_vsync, 1'b0);
          end
          2239: check_bit("s_vsync_63_34", s_vsync, 1'b0);
          2240: check_bit("s_vsync_rise", s_vsync, 1'b1);
          2559: begin
            check_xy("s_frame_end", s_x, s_y, 63, 39);
            check_bit("s_active_63_39", s_active, 1'b0);
          end
          2560: begin
            check_xy("s_frame_wrap", s_x, s_y, 0, 0);
            check_bit("s_active_wrap", s_active, 1'b1);
          end
          3870: check_xy("s_pre_abort", s_x, s_y, 30, 20);
          default: ;
        endcase
      end
    end
  end

  initial begin
    // Reset held low for 5 clocks.
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    // Run past one full scaled frame into the next, stopping at (30,20).
    repeat (3870) @(posedge clk);
    // Abort mid-frame, hold reset for 3 clocks, then restart.
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
